// File: rtl/scan_chain_controller.sv
// rtl/scan_chain_controller.sv - host-side scan frame sequencer and processor enable gating
module scan_chain_controller #(
    parameter int CHAIN_LEN = 64,
    parameter int CNT_W     = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic host_scan_in,
    input  logic host_shift,
    input  logic host_run,
    input  logic host_step,
    input  logic core_halt,
    input  logic chain_scan_out,
    output logic chain_scan_in,
    output logic host_scan_out,
    output logic scan_enable,
    output logic processor_enable,
    output logic frame_done,
    output logic halted
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        RUN,
        STEP,
        HALTED
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_next;
    logic             frame_done_next;
    logic             host_step_q;
    logic             step_rise;

    // host_step_q follows host_step in every state, so an edge seen mid-frame or mid-run is consumed there
    assign step_rise = host_step & ~host_step_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            frame_done  <= 1'b0;
            host_step_q <= 1'b0;
        end else begin
            state       <= state_next;
            bit_cnt     <= bit_cnt_next;
            frame_done  <= frame_done_next;
            host_step_q <= host_step;
        end
    end

    always_comb begin
        state_next      = state;
        bit_cnt_next    = bit_cnt;
        frame_done_next = 1'b0;
        case (state)
            IDLE: begin
                if (host_shift) begin
                    state_next   = SHIFT;
                    bit_cnt_next = LAST_BIT;
                end else if (step_rise) begin
                    state_next = STEP;
                end else if (host_run) begin
                    state_next = RUN;
                end
            end
            SHIFT: begin
                // Frame is atomic: host requests are not looked at until the last bit
                if (bit_cnt == '0) begin
                    state_next      = IDLE;
                    frame_done_next = 1'b1;
                end else begin
                    bit_cnt_next = bit_cnt - CNT_W'(1);
                end
            end
            RUN: begin
                if (core_halt) begin
                    state_next = HALTED;
                end else if (!host_run) begin
                    state_next = IDLE;
                end
            end
            STEP: begin
                state_next = IDLE;
            end
            HALTED: begin
                if (!host_run) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign scan_enable      = (state == SHIFT);
    assign processor_enable = (state == RUN) || (state == STEP);
    assign halted           = (state == HALTED);
    assign chain_scan_in    = host_scan_in & scan_enable;
    assign host_scan_out    = chain_scan_out;

endmodule

// File: tb/tb_scan_chain_controller.sv
// tb/tb_scan_chain_controller.sv - table, directed and random checks against a frame/mode model
module tb_scan_chain_controller;

    localparam int CHAIN_LEN = 64;
    localparam int CNT_W     = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic host_scan_in = 1'b0;
    logic host_shift = 1'b0;
    logic host_run = 1'b0;
    logic host_step = 1'b0;
    logic core_halt = 1'b0;
    logic chain_scan_out;
    logic chain_scan_in;
    logic host_scan_out;
    logic scan_enable;
    logic processor_enable;
    logic frame_done;
    logic halted;

    int total = 0;
    int bad = 0;

    scan_chain_controller #(.CHAIN_LEN(CHAIN_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .host_scan_in(host_scan_in),
        .host_shift(host_shift),
        .host_run(host_run),
        .host_step(host_step),
        .core_halt(core_halt),
        .chain_scan_out(chain_scan_out),
        .chain_scan_in(chain_scan_in),
        .host_scan_out(host_scan_out),
        .scan_enable(scan_enable),
        .processor_enable(processor_enable),
        .frame_done(frame_done),
        .halted(halted)
    );

    always #5 clk = ~clk;

    // Behaves as the physical chain: a CHAIN_LEN-bit shift register clocked by scan_enable
    logic [CHAIN_LEN-1:0] chain = '0;
    always @(posedge clk) if (scan_enable) chain <= {chain[CHAIN_LEN-2:0], chain_scan_in};
    assign chain_scan_out = chain[CHAIN_LEN-1];

    int se_cnt = 0;
    int pe_cnt = 0;
    always @(posedge clk) begin
        se_cnt <= se_cnt + int'(scan_enable);
        pe_cnt <= pe_cnt + int'(processor_enable);
    end

    // Model: bits remaining in the current frame plus flags for run / halted / single-step
    int m_left = 0;
    bit m_run = 0, m_halt = 0, m_step = 0, m_fd = 0, m_prev_step = 0;

    task automatic model_reset();
        m_left = 0; m_run = 0; m_halt = 0; m_step = 0; m_fd = 0; m_prev_step = 0;
    endtask

    task automatic model_edge(input bit sh, input bit rn, input bit sp, input bit hl);
        bit fd = 0;
        if (m_left > 0) begin
            m_left--;
            fd = (m_left == 0);
        end else if (m_step) begin
            m_step = 0;
        end else if (m_halt) begin
            if (!rn) m_halt = 0;
        end else if (m_run) begin
            if (hl) begin m_run = 0; m_halt = 1; end
            else if (!rn) m_run = 0;
        end else if (sh) begin
            m_left = CHAIN_LEN;
        end else if (sp && !m_prev_step) begin
            m_step = 1;
        end else if (rn) begin
            m_run = 1;
        end
        m_fd = fd;
        m_prev_step = sp;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("scan_enable", 32'(scan_enable), 32'(m_left > 0));
        check("processor_enable", 32'(processor_enable), 32'(m_run | m_step));
        check("halted", 32'(halted), 32'(m_halt));
        check("frame_done", 32'(frame_done), 32'(m_fd));
        check("enable_overlap", 32'(scan_enable & processor_enable), 32'd0);
    endtask

    // One clock: check current outputs, drive new inputs at the falling edge, advance the model
    task automatic tick(input bit sh, input bit rn, input bit sp, input bit hl, input bit d);
        @(negedge clk);
        check_outputs();
        host_shift = sh; host_run = rn; host_step = sp; core_halt = hl; host_scan_in = d;
        #1;
        check("chain_scan_in", 32'(chain_scan_in), 32'(d & (m_left > 0)));
        check("host_scan_out", 32'(host_scan_out), 32'(chain_scan_out));
        model_edge(sh, rn, sp, hl);
    endtask

    typedef struct {
        bit sh, rn, sp, hl;
        bit se, pe, ht;
    } vec_t;

    vec_t vecs[13];
    logic [CHAIN_LEN-1:0] frame1;
    logic [CHAIN_LEN-1:0] unloaded;
    int base;

    initial begin
        vecs[0]  = '{0,1,0,0, 0,1,0};
        vecs[1]  = '{0,1,0,0, 0,1,0};
        vecs[2]  = '{0,1,0,1, 0,0,1};
        vecs[3]  = '{1,1,1,0, 0,0,1};
        vecs[4]  = '{0,0,0,0, 0,0,0};
        vecs[5]  = '{0,0,1,0, 0,1,0};
        vecs[6]  = '{0,0,1,0, 0,0,0};
        vecs[7]  = '{0,0,1,0, 0,0,0};
        vecs[8]  = '{0,0,0,0, 0,0,0};
        vecs[9]  = '{0,1,1,0, 0,1,0};
        vecs[10] = '{0,1,1,0, 0,0,0};
        vecs[11] = '{0,1,1,0, 0,1,0};
        vecs[12] = '{0,0,0,0, 0,0,0};

        // Reset state, held asserted across clock edges
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {28'd0, scan_enable, processor_enable, frame_done, halted}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Table of mode transitions; results sampled just after the edge
        foreach (vecs[i]) begin
            tick(vecs[i].sh, vecs[i].rn, vecs[i].sp, vecs[i].hl, 1'b0);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_se", i), 32'(scan_enable), 32'(vecs[i].se));
            check($sformatf("vec%0d_pe", i), 32'(processor_enable), 32'(vecs[i].pe));
            check($sformatf("vec%0d_halted", i), 32'(halted), 32'(vecs[i].ht));
        end

        // Load 0xA5 pattern, then unload it with a frame of zeros
        frame1 = {8{8'hA5}};
        tick(1, 0, 0, 0, 0);
        base = se_cnt;
        for (int i = 0; i < CHAIN_LEN; i++) tick(0, 0, 0, 0, frame1[i]);
        tick(0, 0, 0, 0, 0);
        check("frame_len", 32'(se_cnt - base), 32'(CHAIN_LEN));
        check("frame_done_pulse", 32'(frame_done), 32'd1);
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < CHAIN_LEN; i++) begin
            tick(0, 0, 0, 0, 0);
            unloaded[i] = host_scan_out;
        end
        tick(0, 0, 0, 0, 0);
        check("unload_lo", unloaded[31:0], frame1[31:0]);
        check("unload_hi", unloaded[63:32], frame1[63:32]);

        // Held host_shift: back-to-back frames separated by one idle cycle
        for (int i = 0; i < 2 * CHAIN_LEN + 4; i++) tick(1, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0);
        repeat (CHAIN_LEN) tick(0, 0, 0, 0, 0);

        // Run, halt at cycle 10, release
        for (int i = 0; i < 10; i++) tick(0, 1, 0, 0, 0);
        tick(0, 1, 0, 1, 0);
        tick(0, 1, 0, 0, 0);
        check("halt_entered", 32'(halted), 32'd1);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        check("halt_released", 32'(halted), 32'd0);

        // Step held for five cycles gives a single enable cycle
        base = pe_cnt;
        repeat (5) tick(0, 0, 1, 0, 0);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        check("step_once", 32'(pe_cnt - base), 32'd1);

        // Mid-frame run/step requests are held off until the frame ends
        tick(1, 0, 0, 0, 0);
        base = pe_cnt;
        for (int i = 0; i < 30; i++) tick(0, 0, 0, 0, i[0]);
        for (int i = 30; i < CHAIN_LEN; i++) tick(0, 1, 1, 0, i[0]);
        check("no_pe_in_frame", 32'(pe_cnt - base), 32'd0);
        tick(0, 1, 1, 0, 0);
        tick(0, 1, 1, 0, 0);
        check("run_after_frame", 32'(processor_enable), 32'd1);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);

        // Asynchronous reset at bit 20 of a frame
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) tick(0, 0, 0, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", {28'd0, scan_enable, processor_enable, frame_done, halted}, 32'd0);
        model_reset();
        @(negedge clk);
        host_shift = 0; host_run = 0; host_step = 0; core_halt = 0;
        rst = 1'b0;
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, 1'($urandom));
        end
        tick(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
